// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
// Consumer end of the radix-4 Booth partial-product interface. Captures one
// set of four rows plus negate bits, sums them serially with the fixed
// sign-extension constant 16'hA800 and returns the 16-bit signed product
// over a valid/ready handshake.
// Build option: define PPACC_DUAL_ROW_EN to fold rows 0/1 into the capture
// cycle and rows 2/3 into a single ACC cycle (same arithmetic result).
module booth_pp_accumulator #(
  parameter int OUT_W = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      pp0,
  input  logic [8:0]       pp1,
  input  logic [8:0]       pp2,
  input  logic [8:0]       pp3,
  input  logic             neg0,
  input  logic             neg1,
  input  logic             neg2,
  input  logic             neg3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Implicit leading ones of rows 1-3 (bits 11, 13, 15) folded into one constant.
  localparam logic [15:0] SIGN_K = 16'hA800;

  // Zero-extend a 9-bit row and its +1 correction, then weight by 4^row.
  function automatic logic [15:0] row_term(input logic [8:0] pp,
                                           input logic       neg,
                                           input logic [1:0] row);
    logic [15:0] t;
    t = {7'd0, pp} + {15'd0, neg};
    row_term = t << {row, 1'b0};
  endfunction

  state_t             state_r;
  logic [15:0]        acc_r;
  logic [1:0]         cnt_r;
`ifndef PPACC_DUAL_ROW_EN
  logic [8:0]         pp1_r;
  logic               neg1_r;
`endif
  logic [8:0]         pp2_r;
  logic [8:0]         pp3_r;
  logic               neg2_r;
  logic               neg3_r;
  logic [TAG_W-1:0]   tag_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [OUT_W-1:0]   product_r;
  logic [TAG_W-1:0]   out_tag_r;

  logic [15:0]        row0_s;
  logic [15:0]        init_s;
  logic [15:0]        acc_add_s;
  logic [15:0]        acc_next_s;
  logic               last_row_s;

  // Accumulator seed loaded on the input handshake.
  always_comb begin
    row0_s = {5'd0, pp0} + {15'd0, neg0};
`ifdef PPACC_DUAL_ROW_EN
    init_s = SIGN_K + row0_s + row_term(pp1, neg1, 2'd1);
`else
    init_s = SIGN_K + row0_s;
`endif
  end

  // Contribution added during the current ACC cycle, and whether it is the last.
  always_comb begin
    acc_add_s  = 16'd0;
    last_row_s = 1'b0;
`ifdef PPACC_DUAL_ROW_EN
    acc_add_s  = row_term(pp2_r, neg2_r, 2'd2) + row_term(pp3_r, neg3_r, 2'd3);
    last_row_s = (cnt_r == 2'd2);
`else
    case (cnt_r)
      2'd1:    acc_add_s = row_term(pp1_r, neg1_r, 2'd1);
      2'd2:    acc_add_s = row_term(pp2_r, neg2_r, 2'd2);
      2'd3:    acc_add_s = row_term(pp3_r, neg3_r, 2'd3);
      default: acc_add_s = 16'd0;
    endcase
    last_row_s = (cnt_r == 2'd3);
`endif
    acc_next_s = acc_r + acc_add_s;
  end

  // Control FSM, operand capture, accumulation and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      acc_r       <= 16'd0;
      cnt_r       <= 2'd0;
`ifndef PPACC_DUAL_ROW_EN
      pp1_r       <= 9'd0;
      neg1_r      <= 1'b0;
`endif
      pp2_r       <= 9'd0;
      pp3_r       <= 9'd0;
      neg2_r      <= 1'b0;
      neg3_r      <= 1'b0;
      tag_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      product_r   <= '0;
      out_tag_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
`ifndef PPACC_DUAL_ROW_EN
            pp1_r  <= pp1;
            neg1_r <= neg1;
            cnt_r  <= 2'd1;
`else
            cnt_r  <= 2'd2;
`endif
            pp2_r      <= pp2;
            pp3_r      <= pp3;
            neg2_r     <= neg2;
            neg3_r     <= neg3;
            tag_r      <= in_tag;
            acc_r      <= init_s;
            state_r    <= ACC;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ACC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + 2'd1;
          if (last_row_s) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            product_r   <= OUT_W'($signed(acc_next_s));
            out_tag_r   <= tag_r;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign product   = product_r;
  assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb_booth_pp_accumulator
// Drives a behavioural radix-4 Booth partial-product generator into the
// accumulator and compares products against plain signed multiplication.
module tb_booth_pp_accumulator;

  localparam int OUT_W = 16;
  localparam int TAG_W = 4;
`ifdef PPACC_DUAL_ROW_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif
  localparam int PERIOD  = LAT + 1;
  localparam int RESET_K = (LAT == 4) ? 2 : 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [10:0]      pp0;
  logic [8:0]       pp1, pp2, pp3;
  logic             neg0, neg1, neg2, neg3;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] product;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  booth_pp_accumulator #(.OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(neg0), .neg1(neg1), .neg2(neg2), .neg3(neg3),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .out_tag(out_tag), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Upstream radix-4 Booth generator: digit j from bits b[2j+1], b[2j], b[2j-1].
  task automatic gen_pp(input logic [7:0] a, input logic [7:0] b,
                        output logic [10:0] p0, output logic [8:0] p1,
                        output logic [8:0] p2, output logic [8:0] p3,
                        output logic [3:0] ng);
    logic [8:0] bx;
    logic [8:0] sel;
    logic [8:0] m;
    logic [8:0] rows [4];
    int d;
    bx = {b, 1'b0};
    p0 = 11'd0;
    ng = 4'd0;
    for (int j = 0; j < 4; j++) begin
      d = -2 * int'(bx[2*j+2]) + int'(bx[2*j+1]) + int'(bx[2*j]);
      if (d == 0) sel = 9'd0;
      else if (d == 1 || d == -1) sel = {a[7], a};
      else sel = {a, 1'b0};
      m = (d < 0) ? ~sel : sel;
      ng[j] = (d < 0);
      rows[j] = {~m[8], m[7:0]};
      if (j == 0) p0 = {~m[8], m[8], m};
    end
    p1 = rows[1];
    p2 = rows[2];
    p3 = rows[3];
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b1;
    pp0 = 11'($urandom);
    pp1 = 9'($urandom);
    pp2 = 9'($urandom);
    pp3 = 9'($urandom);
    {neg3, neg2, neg1, neg0} = 4'($urandom);
    in_tag = TAG_W'($urandom);
  endtask

  task automatic drive_set(input logic [10:0] p0, input logic [8:0] p1,
                           input logic [8:0] p2, input logic [8:0] p3,
                           input logic [3:0] ng, input logic [3:0] tg);
    pp0 = p0; pp1 = p1; pp2 = p2; pp3 = p3;
    {neg3, neg2, neg1, neg0} = ng;
    in_tag = tg;
    in_valid = 1'b1;
  endtask

  // One full transaction starting just after a falling edge.
  task automatic run_txn(input logic [10:0] p0, input logic [8:0] p1,
                         input logic [8:0] p2, input logic [8:0] p3,
                         input logic [3:0] ng, input logic [3:0] tg,
                         input logic [15:0] exp16, input int stall,
                         input bit scramble, output int hs_cyc);
    int n;
    logic [OUT_W-1:0] exp_p;
    exp_p = OUT_W'($signed(exp16));
    drive_set(p0, p1, p2, p3, ng, tg);
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    if (scramble) scramble_inputs();
    else in_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      chk("out_valid_lat", 32'(out_valid), 32'(k == LAT));
      if (scramble) scramble_inputs();
    end
    chk("product", 32'(product), 32'(exp_p));
    chk("out_tag", 32'(out_tag), 32'(tg));
    for (int s = 1; s <= stall; s++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_product", 32'(product), 32'(exp_p));
      chk("hold_tag", 32'(out_tag), 32'(tg));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      if (s == stall) out_ready = 1'b1;
    end
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  logic signed [7:0] da [4];
  logic signed [7:0] db [4];
  logic [15:0]       dexp [4];

  initial begin
    logic [10:0] g0;
    logic [8:0]  g1, g2, g3;
    logic [3:0]  gn;
    logic [3:0]  tg;
    logic signed [7:0] ra, rb;
    logic [15:0] rexp;
    int hs, prev_hs, n;

    da   = '{8'h80, 8'h7F, 8'hFF, 8'h7F};
    db   = '{8'h80, 8'h80, 8'h01, 8'h7F};
    dexp = '{16'h4000, 16'hC080, 16'hFFFF, 16'h3F01};

    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    pp0 = 11'd0; pp1 = 9'd0; pp2 = 9'd0; pp3 = 9'd0;
    {neg3, neg2, neg1, neg0} = 4'd0;
    in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    reset_n = 1'b1;

    // All-zero Booth digits.
    run_txn(11'h400, 9'h100, 9'h100, 9'h100, 4'h0, 4'h5, 16'h0000, 0, 1'b0, hs);
    prev_hs = hs;

    // Corner products, back to back with out_ready high.
    for (int i = 0; i < 4; i++) begin
      gen_pp(da[i], db[i], g0, g1, g2, g3, gn);
      tg = 4'(i + 8);
      run_txn(g0, g1, g2, g3, gn, tg, dexp[i], 0, 1'b0, hs);
      chk("throughput", 32'(hs - prev_hs), 32'(PERIOD));
      prev_hs = hs;
    end

    // Backpressure for six cycles.
    ra = 8'sh5A; rb = 8'shC3;
    gen_pp(ra, rb, g0, g1, g2, g3, gn);
    rexp = 16'(int'(ra) * int'(rb));
    run_txn(g0, g1, g2, g3, gn, 4'hA, rexp, 6, 1'b0, hs);

    // Inputs change after the capture.
    ra = 8'sh81; rb = 8'sh37;
    gen_pp(ra, rb, g0, g1, g2, g3, gn);
    rexp = 16'(int'(ra) * int'(rb));
    run_txn(g0, g1, g2, g3, gn, 4'h3, rexp, 0, 1'b1, hs);

    // Reset while accumulating.
    ra = 8'sh33; rb = 8'sh9D;
    gen_pp(ra, rb, g0, g1, g2, g3, gn);
    drive_set(g0, g1, g2, g3, gn, 4'hC);
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= RESET_K; k++) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_product", 32'(product), 32'd0);
    chk("rst_mid_tag", 32'(out_tag), 32'd0);
    reset_n = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("rst_no_output", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    rexp = 16'(int'(ra) * int'(rb));
    run_txn(g0, g1, g2, g3, gn, 4'hC, rexp, 0, 1'b0, hs);

    // Randomized operands, stalls and post-capture input noise.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      tg = 4'($urandom);
      gen_pp(ra, rb, g0, g1, g2, g3, gn);
      rexp = 16'(int'(ra) * int'(rb));
      run_txn(g0, g1, g2, g3, gn, tg, rexp, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), hs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
